// File: rtl/mfp_reset_sequencer.sv
// Board reset sequencer: synchronises/debounces reset requests, qualifies PLL lock, releases
// peripheral reset before core reset and records the cause. Optional watchdog: MFP_RESET_WATCHDOG_EN.
module mfp_reset_sequencer #(
    parameter int                N_SRC                 = 3,
    parameter int                DEBOUNCE_CYCLES       = 4,
    parameter int                HOLD_CYCLES           = 8,
    parameter int                LOCK_STABLE_CYCLES    = 16,
    parameter int                PERIPH_TO_CORE_CYCLES = 4,
    parameter logic [N_SRC-1:0]  COLD_MASK             = 3'b010,
    parameter int                WDT_CYCLES            = 1024
) (
    input  logic                SI_ClkIn,
    input  logic                SI_Reset,
    input  logic [N_SRC-1:0]    rst_req,
    input  logic                pll_lock,
    input  logic                wdt_kick,
    output logic                periph_reset,
    output logic                sys_reset,
    output logic                cold_reset,
    output logic                ready,
    output logic [N_SRC+2:0]    rst_cause
);

    localparam int CNT_MAX_HL = (HOLD_CYCLES > LOCK_STABLE_CYCLES) ? HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_HL > PERIPH_TO_CORE_CYCLES) ? CNT_MAX_HL : PERIPH_TO_CORE_CYCLES;
    localparam int CW         = $clog2(CNT_MAX + 1);
    localparam int DW         = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_DONE   = CW'(LOCK_STABLE_CYCLES);
    localparam logic [CW-1:0] PERIPH_LAST = CW'(PERIPH_TO_CORE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT     = CW'(CNT_MAX);
    localparam logic [DW-1:0] DEB_DONE    = DW'(DEBOUNCE_CYCLES);
    localparam logic [N_SRC+2:0] CAUSE_POR = {1'b1, {(N_SRC+2){1'b0}}};

    typedef enum logic [3:0] {
        ST_ASSERT    = 4'b0001,
        ST_WAIT_LOCK = 4'b0010,
        ST_PERIPH    = 4'b0100,
        ST_RUN       = 4'b1000
    } state_t;

    state_t              state, state_nxt;
    logic [N_SRC-1:0]    req_s1, req_s2;
    logic                lock_s1, lock_s2;
    logic [N_SRC-1:0]    qual;
    logic                any_qual, lock_lost, wdt_exp, enter_assert, enter_run;
    logic [CW-1:0]       cnt, cnt_inc;

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            req_s1  <= '0;
            req_s2  <= '0;
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
        end else begin
            req_s1  <= rst_req;
            req_s2  <= req_s1;
            lock_s1 <= pll_lock;
            lock_s2 <= lock_s1;
        end
    end

    for (genvar i = 0; i < N_SRC; i++) begin : g_deb
        logic [DW-1:0] deb_cnt;
        always_ff @(posedge SI_ClkIn) begin
            if (SI_Reset || !req_s2[i])
                deb_cnt <= '0;
            else if (deb_cnt != DEB_DONE)
                deb_cnt <= deb_cnt + DW'(1);
        end
        assign qual[i] = (deb_cnt == DEB_DONE);
    end

    assign any_qual  = |qual;
    assign lock_lost = !lock_s2 && (state == ST_PERIPH || state == ST_RUN);

`ifdef MFP_RESET_WATCHDOG_EN
    localparam int WW = $clog2(WDT_CYCLES + 1);
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
    logic [WW-1:0] wdt_cnt;

    // Counts only while staying in RUN; a kick or any exit restarts it.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset || wdt_kick || state != ST_RUN || state_nxt != ST_RUN)
            wdt_cnt <= '0;
        else if (wdt_cnt != WDT_LAST)
            wdt_cnt <= wdt_cnt + WW'(1);
    end
    assign wdt_exp = (state == ST_RUN) && (wdt_cnt == WDT_LAST) && !wdt_kick;
`else
    logic unused_wdt;
    assign unused_wdt = wdt_kick | (WDT_CYCLES < 1);
    assign wdt_exp    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ASSERT:
                if (!any_qual && cnt == HOLD_LAST) state_nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK:
                if (any_qual)                        state_nxt = ST_ASSERT;
                else if (lock_s2 && cnt == LOCK_DONE) state_nxt = ST_PERIPH;
            ST_PERIPH:
                if (any_qual || !lock_s2)            state_nxt = ST_ASSERT;
                else if (cnt == PERIPH_LAST)         state_nxt = ST_RUN;
            ST_RUN:
                if (any_qual || !lock_s2 || wdt_exp) state_nxt = ST_ASSERT;
            default:
                state_nxt = ST_ASSERT;
        endcase
    end

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) state <= ST_ASSERT;
        else          state <= state_nxt;
    end

    // One shared dwell counter; it restarts from zero in every new state.
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + CW'(1);

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset || state_nxt != state) begin
            cnt <= '0;
        end else begin
            case (state)
                ST_ASSERT:    cnt <= any_qual ? '0 : cnt_inc;
                ST_WAIT_LOCK: cnt <= lock_s2 ? cnt_inc : '0;
                ST_PERIPH:    cnt <= cnt_inc;
                default:      cnt <= '0;
            endcase
        end
    end

    assign enter_assert = (state_nxt == ST_ASSERT) && (state != ST_ASSERT);
    assign enter_run    = (state_nxt == ST_RUN) && (state != ST_RUN);

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset)
            cold_reset <= 1'b1;
        else if (enter_assert)
            cold_reset <= cold_reset | (|(qual & COLD_MASK));
        else if (enter_run)
            cold_reset <= 1'b0;
    end

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset)
            rst_cause <= CAUSE_POR;
        else if (enter_assert)
            rst_cause <= {1'b0, wdt_exp, lock_lost, qual};
        else if (state == ST_ASSERT || state == ST_WAIT_LOCK)
            rst_cause <= rst_cause | {3'b000, qual};
    end

    assign periph_reset = state[0] | state[1];
    assign sys_reset    = ~state[3];
    assign ready        = state[3];

endmodule

// File: tb/tb_mfp_reset_sequencer.sv
// Bench for mfp_reset_sequencer: expected output changes (cycle + value) are queued as stimulus
// is applied and compared whenever the outputs change.
module tb_mfp_reset_sequencer;

    localparam int N_SRC = 3;

    typedef struct {
        int         cyc;
        logic [9:0] vec;
    } evt_t;

    logic             clk = 1'b0;
    logic             si_reset;
    logic [N_SRC-1:0] rst_req;
    logic             pll_lock;
    logic             wdt_kick;
    logic             periph_reset, sys_reset, cold_reset, ready;
    logic [N_SRC+2:0] rst_cause;

    evt_t       exp_q[$];
    int         cyc = -1;
    int         checks = 0;
    int         errors = 0;
    logic       mon_en = 1'b0;
    logic [9:0] prev;
    int         c, d, start, last_kick;

    localparam logic [9:0] RST_VEC = {1'b1, 1'b1, 1'b1, 1'b0, 6'b100000};

    mfp_reset_sequencer dut (
        .SI_ClkIn     (clk),
        .SI_Reset     (si_reset),
        .rst_req      (rst_req),
        .pll_lock     (pll_lock),
        .wdt_kick     (wdt_kick),
        .periph_reset (periph_reset),
        .sys_reset    (sys_reset),
        .cold_reset   (cold_reset),
        .ready        (ready),
        .rst_cause    (rst_cause)
    );

    always #5 clk = ~clk;

    // Edge numbering: edge 0 is the first edge sampled with reset low.
    always @(posedge clk) cyc <= si_reset ? -1 : cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic logic [9:0] cur_vec();
        return {periph_reset, sys_reset, cold_reset, ready, rst_cause};
    endfunction

    function automatic logic [9:0] mk(input logic p, input logic s, input logic cr,
                                      input logic r, input logic [5:0] cause);
        return {p, s, cr, r, cause};
    endfunction

    task automatic exp_evt(input int at, input logic [9:0] v);
        evt_t e;
        e.cyc = at;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic at_cycle(input int n);
        int g = 0;
        while (cyc != n && g < 5000) begin
            @(posedge clk); #1;
            g++;
        end
        if (cyc != n) check("at_cycle_timeout", cyc, n);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        logic [9:0] v;
        evt_t       e;
        if (mon_en) begin
            v = cur_vec();
            if (v !== prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_change", {22'd0, v}, {22'd0, prev});
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_outputs", {22'd0, v}, {22'd0, e.vec});
                end
                prev = v;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench still running, required to finish");
        $fatal(1, "timeout");
    end

    initial begin
        si_reset = 1'b1;
        pll_lock = 1'b1;
        rst_req  = '0;
        wdt_kick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_values", {22'd0, cur_vec()}, {22'd0, RST_VEC});
        prev   = cur_vec();
        mon_en = 1'b1;

        // Power-up sequence
        exp_evt(24, mk(0, 1, 1, 0, 6'b100000));
        exp_evt(28, mk(0, 0, 0, 1, 6'b100000));
        si_reset = 1'b0;
        drain("powerup", 60);

        // 3-cycle bounce must be filtered, 4-cycle request must reset
        c = cyc;
        rst_req[0] = 1'b1;
        at_cycle(c + 3);
        rst_req[0] = 1'b0;
        at_cycle(c + 15);
        c = cyc;
        exp_evt(c + 7,  mk(1, 1, 0, 0, 6'b000001));
        exp_evt(c + 32, mk(0, 1, 0, 0, 6'b000001));
        exp_evt(c + 36, mk(0, 0, 0, 1, 6'b000001));
        rst_req[0] = 1'b1;
        at_cycle(c + 4);
        rst_req[0] = 1'b0;
        drain("request", 60);

        // Cold source held 10 cycles
        c = cyc;
        exp_evt(c + 7,  mk(1, 1, 1, 0, 6'b000010));
        exp_evt(c + 38, mk(0, 1, 1, 0, 6'b000010));
        exp_evt(c + 42, mk(0, 0, 0, 1, 6'b000010));
        rst_req[1] = 1'b1;
        at_cycle(c + 10);
        rst_req[1] = 1'b0;
        drain("cold", 80);

        // Request and lock loss on the same cycle, then SI_Reset pulse in PERIPH
        c = cyc;
        exp_evt(c + 7,  mk(1, 1, 0, 0, 6'b001100));
        exp_evt(c + 32, mk(0, 1, 0, 0, 6'b001100));
        rst_req[2] = 1'b1;
        at_cycle(c + 4);
        rst_req[2] = 1'b0;
        pll_lock   = 1'b0;
        at_cycle(c + 10);
        pll_lock   = 1'b1;
        at_cycle(c + 33);
        exp_evt(-1, RST_VEC);
        si_reset = 1'b1;
        @(posedge clk); #1;
        si_reset = 1'b0;

        // Power-up with a one-cycle lock glitch in WAIT_LOCK
        exp_evt(34, mk(0, 1, 1, 0, 6'b100000));
        exp_evt(38, mk(0, 0, 0, 1, 6'b100000));
        at_cycle(14);
        pll_lock = 1'b0;
        at_cycle(15);
        pll_lock = 1'b1;
        drain("lock_glitch", 60);

        // Lock loss in RUN; no lock keeps the block in reset
        c = cyc;
        exp_evt(c + 3, mk(1, 1, 0, 0, 6'b001000));
        pll_lock = 1'b0;
        at_cycle(c + 70);
        check("no_lock_sys_reset", sys_reset, 1'b1);
        d = cyc;
        exp_evt(d + 19, mk(0, 1, 0, 0, 6'b001000));
        exp_evt(d + 23, mk(0, 0, 0, 1, 6'b001000));
        pll_lock = 1'b1;
        drain("lock_loss", 60);

`ifdef MFP_RESET_WATCHDOG_EN
        start = cyc;
        for (int k = 0; k < 3; k++) begin
            at_cycle(start + 10 + 1000 * k);
            wdt_kick = 1'b1;
            at_cycle(start + 11 + 1000 * k);
            wdt_kick = 1'b0;
        end
        last_kick = start + 2011;
        exp_evt(last_kick + 1024, mk(1, 1, 0, 0, 6'b010000));
        exp_evt(last_kick + 1049, mk(0, 1, 0, 0, 6'b010000));
        exp_evt(last_kick + 1053, mk(0, 0, 0, 1, 6'b010000));
        drain("watchdog", 1200);
`else
        start = cyc;
        for (int k = 0; k < 3; k++) begin
            at_cycle(start + 5 + 400 * k);
            wdt_kick = 1'b1;
            at_cycle(start + 6 + 400 * k);
            wdt_kick = 1'b0;
        end
        at_cycle(start + 1300);
        check("no_wdt_ready", ready, 1'b1);
        check("no_wdt_cause", rst_cause, 6'b001000);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
